result_uart_tx: RTL and testbench
=================================

Name: result_uart_tx

Overview:
- Serialises the 16-bit datapath result word (register r3 output of the register-file/ALU datapath) onto a UART TX line for host-side debug and result readout.
- Sits directly downstream of the datapath result port. Transmits on an explicit start request, or automatically whenever the result word changes.
- Frames are 8N1, LSB-first. A word is sent as N/8 bytes, least-significant byte first.

Parameters:
- clk_freq, 50000000, system clock frequency in Hz.
- baud_rate, 57600, UART bit rate.
- N, 16, result word width. Must be a multiple of 8. Byte count B = N/8.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-low reset.
- i_data  input  N  result word from the datapath.
- i_start  input  1  transmit request; sampled only when idle.
- i_auto  input  1  when high, any change of i_data versus the last sent word triggers a transmission.
- o_txd  output  1  UART serial line; idles high.
- o_busy  output  1  high while a word transmission is in progress.
- o_done  output  1  one-cycle pulse when the last stop bit of a word completes.

Behaviour:
- Bit divisor DIV = clk_freq / baud_rate, integer truncated (868 at defaults). Every bit lasts exactly DIV clock cycles.
- Reset (rst = 0 at a clock edge) takes effect at that edge, regardless of state:
  - state = IDLE, o_txd = 1, o_busy = 0, o_done = 0.
  - Baud counter, bit counter and byte counter = 0.
  - Shift register = 0; last_sent register = 0.
- Reset mid-frame: the frame is aborted. o_txd = 1 from that edge, and no o_done is produced.
- States:
  - IDLE:
    - Trigger = i_start OR (i_auto AND i_data != last_sent).
    - On trigger: latch i_data into the shift register and into last_sent, set byte index = 0, go to START_BIT.
  - START_BIT: o_txd = 0 for DIV cycles, then go to DATA_BITS.
  - DATA_BITS: o_txd = current byte bit[k], k = 0..7, each for DIV cycles, then go to STOP_BIT.
  - STOP_BIT: o_txd = 1 for DIV cycles. Then:
    - If byte index < B-1: increment byte index and go to START_BIT with the next byte.
    - Else: go to IDLE and pulse o_done.
- Timing, with E0 = the edge at which the trigger is accepted:
  - o_txd falls at E0 and o_busy rises at E0.
  - A word occupies exactly 10·DIV·B cycles.
  - At edge E0 + 10·DIV·B: state = IDLE, o_busy = 0, o_done = 1 for exactly one cycle.
  - There is no gap between bytes within a word.
- o_busy = 1 in every state except IDLE.
- i_start and i_auto changes while busy are ignored (no queuing). i_data is not resampled during a frame.
- Auto change-detect is evaluated only in IDLE. A change that occurred while busy is therefore sent immediately after done, if the value still differs from last_sent.
- i_start and an auto trigger in the same cycle produce one transmission.
- The o_done cycle is an IDLE cycle. A trigger in that cycle is accepted, so the next start bit begins on the following edge. Back-to-back words therefore have exactly one extra idle-high cycle between them.
- A word equal to last_sent is still sent when i_start is asserted.
- All outputs are registered; there is no combinational path from inputs to o_txd.

Test Plan:
Bench parameters: clk_freq = 80, baud_rate = 10, so DIV = 8, N = 16, B = 2.
1. Reset: hold rst = 0 for 3 cycles with i_start = 1 -> o_txd = 1, o_busy = 0, o_done = 0 throughout. No frame starts until rst = 1.
2. Single word: pulse i_start with i_data = 0xA53C.
   - o_txd sequence in 8-cycle bits: 0, then 0,0,1,1,1,1,0,0 (0x3C LSB-first), then 1.
   - Then 0, then 1,0,1,0,0,1,0,1 (0xA5 LSB-first), then 1.
   - o_busy is high for exactly 160 cycles; o_done is high at cycle 160 only.
3. Ignored request: during test 2, pulse i_start with i_data = 0x1234 at cycle 50 -> bitstream is unchanged and exactly one o_done occurs.
4. Auto mode: i_auto = 1.
   - Change i_data from 0x0000 to 0x0007 -> bytes 0x07, 0x00 are sent.
   - Hold 0x0007 -> no retransmission for 500 cycles.
   - Change to 0x0008 mid-frame -> the second word's start bit begins on the edge after o_done.
5. Reset mid-frame: assert rst = 0 at cycle 45 of a 0xFFFF frame.
   - o_txd = 1 and o_busy = 0 from that edge; no o_done.
   - After release with i_auto = 1 and i_data = 0xFFFF, the word is re-sent because last_sent was cleared to 0.
6. Back-to-back: hold i_start = 1 with i_data = 0x00FF -> frames repeat every 161 cycles, each new start bit directly after its o_done cycle.

Source files
------------

// File: rtl/result_uart_tx.sv
// -----------------------------------------------------------------------------
// result_uart_tx
//
// Purpose:
//   Serialises the datapath result word onto an 8N1 UART line, LSB first.
//   The word is sent as N/8 bytes, least-significant byte first, back to back
//   with no gap between bytes. A transmission starts on an explicit request,
//   or (in auto mode) whenever the result word differs from the last word sent.
//
// Ports:
//   clk      system clock, all state changes on the rising edge
//   rst      synchronous, active-low reset
//   i_data   result word from the datapath (N bits)
//   i_start  transmit request, sampled only while idle
//   i_auto   auto mode: send whenever i_data differs from the last sent word
//   o_txd    UART serial line, idles high
//   o_busy   high while a word is in flight
//   o_done   one-cycle pulse when the final stop bit of a word completes
// -----------------------------------------------------------------------------
module result_uart_tx #(
  parameter int clk_freq  = 50000000,
  parameter int baud_rate = 57600,
  parameter int N         = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] i_data,
  input  logic         i_start,
  input  logic         i_auto,
  output logic         o_txd,
  output logic         o_busy,
  output logic         o_done
);

  localparam int DIV = clk_freq / baud_rate;
  localparam int B   = N / 8;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW  = (B > 1) ? $clog2(B) : 1;

  localparam logic [CW-1:0] DIV_M1    = CW'(DIV - 1);
  localparam logic [BW-1:0] LAST_BYTE = BW'(B - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START_BIT = 2'd1,
    DATA_BITS = 2'd2,
    STOP_BIT  = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  baud_q, baud_d;
  logic [2:0]     bit_q, bit_d;
  logic [BW-1:0]  byte_q, byte_d;
  logic [N-1:0]   shift_q, shift_d;
  logic [N-1:0]   last_q, last_d;
  logic           txd_q, txd_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic           baud_end;
  logic           trigger;

  assign baud_end = (baud_q == DIV_M1);
  assign trigger  = i_start | (i_auto & (i_data != last_q));

  // Next-state logic. o_txd is registered, so the value loaded here is the
  // line level for the bit that begins at the coming edge.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    shift_d = shift_q;
    last_d  = last_q;
    txd_d   = txd_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        txd_d  = 1'b1;
        baud_d = '0;
        bit_d  = '0;
        if (trigger) begin
          shift_d = i_data;
          last_d  = i_data;
          byte_d  = '0;
          txd_d   = 1'b0;
          state_d = START_BIT;
        end
      end

      START_BIT: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          txd_d   = shift_q[0];
          state_d = DATA_BITS;
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end

      DATA_BITS: begin
        if (baud_end) begin
          baud_d = '0;
          // Shifting after every data bit leaves bit 0 of the next byte
          // in shift_q[0] once the current byte is exhausted.
          shift_d = shift_q >> 1;
          if (bit_q == 3'd7) begin
            txd_d   = 1'b1;
            state_d = STOP_BIT;
          end else begin
            bit_d = bit_q + 3'd1;
            txd_d = shift_q[1];
          end
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end

      STOP_BIT: begin
        if (baud_end) begin
          baud_d = '0;
          if (byte_q == LAST_BYTE) begin
            txd_d   = 1'b1;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            byte_d  = byte_q + BW'(1);
            txd_d   = 1'b0;
            state_d = START_BIT;
          end
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end

      default: begin
        txd_d   = 1'b1;
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      shift_q <= '0;
      last_q  <= '0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      shift_q <= shift_d;
      last_q  <= last_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign o_txd  = txd_q;
  assign o_busy = busy_q;
  assign o_done = done_q;

endmodule

// File: tb/tb_result_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_result_uart_tx
//
// Directed bench for result_uart_tx with DIV = 8, N = 16 (two bytes, 160
// cycles per word). Expected line patterns are hand-written 20-bit vectors,
// bit i = line level during bit period i of the word:
//   {stop, byte1, start, stop, byte0, start}
// -----------------------------------------------------------------------------
module tb_result_uart_tx;

  logic        clk;
  logic        rst;
  logic [15:0] i_data;
  logic        i_start;
  logic        i_auto;
  logic        o_txd;
  logic        o_busy;
  logic        o_done;

  int n_checks = 0;
  int n_errors = 0;

  result_uart_tx #(
    .clk_freq (80),
    .baud_rate(10),
    .N        (16)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .i_data (i_data),
    .i_start(i_start),
    .i_auto (i_auto),
    .o_txd  (o_txd),
    .o_busy (o_busy),
    .o_done (o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock edge, then settle before sampling or driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called right after the start edge E0 has been sampled. Follows the word
  // through cycles 0..159 and ends with the E0+160 (done) cycle sampled.
  // Optionally drives new inputs at cycle inj_c to prove they are ignored.
  task automatic watch_word(input string tag, input logic [19:0] exp,
                            input int inj_c, input logic [15:0] inj_d,
                            input logic inj_s);
    int bad_txd = 0;
    int busy_n  = 0;
    int done_n  = 0;
    for (int c = 0; c < 160; c++) begin
      if (c > 0) tick();
      if (o_txd !== exp[c/8]) bad_txd++;
      if (o_busy === 1'b1) busy_n++;
      if (o_done !== 1'b0) done_n++;
      if (c == inj_c) begin
        i_data = inj_d;
        if (inj_s) i_start = 1'b1;
      end else if (inj_s && c == inj_c + 1) begin
        i_start = 1'b0;
      end
    end
    check({tag, "_txd_bits"}, bad_txd, 0);
    check({tag, "_busy_len"}, busy_n, 160);
    check({tag, "_early_done"}, done_n, 0);
    tick();
    check({tag, "_done"}, {31'd0, o_done}, 1);
    check({tag, "_busy_end"}, {31'd0, o_busy}, 0);
    check({tag, "_txd_end"}, {31'd0, o_txd}, 1);
    $display("word %s: line bits=%0d busy=%0d", tag, 160 - bad_txd, busy_n);
  endtask

  initial begin
    int cnt;
    rst     = 1'b0;
    i_data  = 16'hA53C;
    i_start = 1'b1;
    i_auto  = 1'b0;

    // 1. Reset held with a pending request.
    for (int k = 0; k < 3; k++) begin
      tick();
      check("rst_txd", {31'd0, o_txd}, 1);
      check("rst_busy", {31'd0, o_busy}, 0);
      check("rst_done", {31'd0, o_done}, 0);
    end

    // 2/3. Release: request accepted on the first edge; a second request
    //      at cycle 50 must not disturb the frame.
    rst = 1'b1;
    tick();
    check("a53c_start_txd", {31'd0, o_txd}, 0);
    check("a53c_start_busy", {31'd0, o_busy}, 1);
    i_start = 1'b0;
    watch_word("a53c", 20'b1_10100101_0_1_00111100_0, 50, 16'h1234, 1'b1);
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (o_busy !== 1'b0 || o_done !== 1'b0 || o_txd !== 1'b1) cnt++;
    end
    check("ignored_req_idle", cnt, 0);

    // 4. Auto mode. Reset first so last_sent is 0 and 0x0000 is not sent.
    i_data = 16'h0000;
    i_auto = 1'b1;
    rst    = 1'b0;
    tick();
    rst = 1'b1;
    cnt = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (o_busy !== 1'b0) cnt++;
    end
    check("auto_zero_quiet", cnt, 0);

    i_data = 16'h0007;
    tick();
    check("w07_start_txd", {31'd0, o_txd}, 0);
    watch_word("w07", 20'b1_00000000_0_1_00000111_0, -1, 16'h0007, 1'b0);

    cnt = 0;
    for (int k = 0; k < 500; k++) begin
      tick();
      if (o_busy !== 1'b0 || o_txd !== 1'b1) cnt++;
    end
    check("hold_no_resend", cnt, 0);

    i_data = 16'h0009;
    tick();
    check("w09_start_txd", {31'd0, o_txd}, 0);
    watch_word("w09", 20'b1_00000000_0_1_00001001_0, 70, 16'h0008, 1'b0);
    tick();
    check("w08_follow_txd", {31'd0, o_txd}, 0);
    check("w08_follow_busy", {31'd0, o_busy}, 1);
    watch_word("w08", 20'b1_00000000_0_1_00001000_0, -1, 16'h0008, 1'b0);

    // 5. Reset in the middle of a 0xFFFF frame (auto mode still on).
    i_data = 16'hFFFF;
    tick();
    check("wffff_start_txd", {31'd0, o_txd}, 0);
    for (int k = 0; k < 44; k++) tick();
    rst = 1'b0;
    tick();
    check("midrst_txd", {31'd0, o_txd}, 1);
    check("midrst_busy", {31'd0, o_busy}, 0);
    cnt = 0;
    for (int k = 0; k < 3; k++) begin
      if (o_done !== 1'b0 || o_busy !== 1'b0) cnt++;
      tick();
    end
    check("midrst_no_done", cnt, 0);
    rst = 1'b1;
    tick();
    check("resend_start_txd", {31'd0, o_txd}, 0);
    check("resend_start_busy", {31'd0, o_busy}, 1);
    watch_word("ffff", 20'b1_11111111_0_1_11111111_0, -1, 16'hFFFF, 1'b0);

    // 6. Back-to-back with i_start held: new start bit right after o_done.
    i_auto  = 1'b0;
    i_data  = 16'h00FF;
    i_start = 1'b1;
    tick();
    check("b2b0_start_txd", {31'd0, o_txd}, 0);
    watch_word("b2b0", 20'b1_00000000_0_1_11111111_0, -1, 16'h00FF, 1'b0);
    tick();
    check("b2b1_start_txd", {31'd0, o_txd}, 0);
    check("b2b1_start_done", {31'd0, o_done}, 0);
    watch_word("b2b1", 20'b1_00000000_0_1_11111111_0, -1, 16'h00FF, 1'b0);
    i_start = 1'b0;
    tick();
    check("b2b_stop_busy", {31'd0, o_busy}, 0);
    check("b2b_stop_done", {31'd0, o_done}, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
